// File: rtl/prog_inv_delay_pkg.sv
// rtl/prog_inv_delay_pkg.sv - shared types, defaults and helpers for the programmable inverting delay line
//
// Holds the FSM state encoding, default sizing and the tap-select clamp helper
// used by prog_inv_delay_line and its stage register.

package prog_inv_delay_pkg;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_MAX_DEPTH = 8;

    typedef enum logic {
        RUN    = 1'b0,
        SETTLE = 1'b1
    } state_t;

    // Saturate a requested delay to the deepest implemented stage.
    // The caller truncates the result to its own SEL_W width.
    function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned max_depth);
        return (sel > max_depth) ? max_depth : sel;
    endfunction

endpackage

// File: rtl/inv_reg_stage.sv
// rtl/inv_reg_stage.sv - one optionally-inverting data/valid register stage of the delay line
//
// Ports:
//   i_clk     rising-edge clock
//   i_rst     synchronous active-high reset (clears data and valid)
//   i_en      advance enable; 0 holds data and valid
//   i_flush   clears valid only, data untouched; wins over i_en
//   i_inv     1 = stored data is the inverse of i_d
//   i_d       data from the previous stage (or din for stage 1)
//   i_d_vld   valid from the previous stage
//   o_q       registered data
//   o_q_vld   registered valid

module inv_reg_stage
    import prog_inv_delay_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_flush,
    input  logic             i_inv,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_d_vld,
    output logic [WIDTH-1:0] o_q,
    output logic             o_q_vld
);

    logic [WIDTH-1:0] r_q;
    logic             r_q_vld;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q     <= '0;
            r_q_vld <= 1'b0;
        end else if (i_flush) begin
            // Reconfiguration drops everything in flight; nothing shifts at this edge.
            r_q_vld <= 1'b0;
        end else if (i_en) begin
            r_q     <= i_d ^ {WIDTH{i_inv}};
            r_q_vld <= i_d_vld;
        end
    end

    assign o_q     = r_q;
    assign o_q_vld = r_q_vld;

endmodule

// File: rtl/prog_inv_delay_line.sv
// rtl/prog_inv_delay_line.sv - run-time programmable, optionally inverting registered delay line
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset
//   i_en         advance enable; 0 holds stages, valids and settle counter
//   i_din        data in
//   i_din_vld    i_din qualifier
//   i_dly_sel    requested delay in enabled cycles, clamped to MAX_DEPTH
//   i_inv_mode   1 = every stage inverts its data
//   o_dout       tapped data, 0 whenever o_dout_vld is 0
//   o_dout_vld   o_dout qualifier
//   o_cfg_busy   high while the pipeline refills after a configuration change

module prog_inv_delay_line
    import prog_inv_delay_pkg::*;
#(
    parameter  int WIDTH     = DEFAULT_WIDTH,
    parameter  int MAX_DEPTH = DEFAULT_MAX_DEPTH,
    localparam int SEL_W     = $clog2(MAX_DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_din_vld,
    input  logic [SEL_W-1:0] i_dly_sel,
    input  logic             i_inv_mode,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_dout_vld,
    output logic             o_cfg_busy
);

    logic [SEL_W-1:0] r_dly_q;
    logic             r_inv_q;
    state_t           r_state;
    logic [SEL_W-1:0] r_cnt;

    logic [SEL_W-1:0] w_sel_clamped;
    logic             w_cfg_change;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_tap;
    logic             w_tap_vld;
    logic             w_out_vld;

    // Index 0 is the live input, so a delay of 0 is a plain combinational bypass
    // through the same tap mux that selects the registered stages.
    logic [WIDTH-1:0] w_stage_q   [0:MAX_DEPTH];
    logic             w_stage_vld [0:MAX_DEPTH];

    assign w_sel_clamped = SEL_W'(clamp_sel(32'(i_dly_sel), 32'(MAX_DEPTH)));
    assign w_cfg_change  = (w_sel_clamped != r_dly_q) || (i_inv_mode != r_inv_q);

    assign w_stage_q[0]   = i_din;
    assign w_stage_vld[0] = i_din_vld;

    for (genvar g = 1; g <= MAX_DEPTH; g++) begin : g_stage
        inv_reg_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_en    (i_en),
            .i_flush (w_cfg_change),
            .i_inv   (r_inv_q),
            .i_d     (w_stage_q[g-1]),
            .i_d_vld (w_stage_vld[g-1]),
            .o_q     (w_stage_q[g]),
            .o_q_vld (w_stage_vld[g])
        );
    end

    always_comb begin
        w_tap     = w_stage_q[r_dly_q];
        w_tap_vld = w_stage_vld[r_dly_q];
    end

    // Keep the outputs quiet for the whole reset pulse so the bypass path
    // cannot leak din while reset is held.
    assign w_out_vld  = w_tap_vld & ~i_rst;
    assign o_dout_vld = w_out_vld;
    assign o_dout     = w_out_vld ? w_tap : '0;
    assign o_cfg_busy = (r_state == SETTLE);

    // Config is sampled every edge, independent of i_en, so a change is seen
    // (and flushes) even while the pipeline is stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dly_q <= '0;
            r_inv_q <= 1'b0;
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_dly_q <= w_sel_clamped;
            r_inv_q <= i_inv_mode;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_cfg_change) begin
            // Any change restarts the refill count against the new depth.
            w_cnt_nxt   = '0;
            w_state_nxt = (w_sel_clamped != '0) ? SETTLE : RUN;
        end else if ((r_state == SETTLE) && i_en) begin
            if (r_cnt == (r_dly_q - SEL_W'(1))) begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt + SEL_W'(1);
            end
        end
    end

endmodule

// File: doc/prog_inv_delay_line.md
Name: prog_inv_delay_line

Overview:
Clocked, parametrised successor to the fixed six-stage inverter chain. It provides a WIDTH-bit registered delay line with up to MAX_DEPTH stages. The tap (delay) is selectable at run time, and each stage optionally inverts its data, reproducing odd/even inverter-chain polarity in cycles instead of gate delays. Valid tracking, stall, flush-on-reconfiguration and a settle indicator are included. It is used in lab experiments on propagation delay and as a generic alignment pipeline.

Parameters:
WIDTH, 8, data bits per stage
MAX_DEPTH, 8, maximum number of register stages (>=1)
SEL_W, $clog2(MAX_DEPTH+1), derived localparam, width of dly_sel

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
en  input  1  advance enable; 0 = all stages, valid bits and settle counter hold
din  input  WIDTH  data in
din_vld  input  1  din qualifier
dly_sel  input  SEL_W  requested delay in enabled cycles, 0..MAX_DEPTH; larger values clamp to MAX_DEPTH
inv_mode  input  1  1 = every stage inverts its data
dout  output  WIDTH  tapped data; forced to 0 whenever dout_vld=0
dout_vld  output  1  dout qualifier
cfg_busy  output  1  high while the pipeline refills after a config change

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - all stage data = 0, all stage valid bits = 0
  - dly_q = 0, inv_q = 0, state = RUN, settle counter = 0
  - outputs after the edge: dout=0, dout_vld=0, cfg_busy=0
  - rst has priority over en and over config changes
- Config register: dly_q <= min(dly_sel, MAX_DEPTH) and inv_q <= inv_mode, updated every edge regardless of en.
- Config change: detected at an edge where clamp(dly_sel) != dly_q or inv_mode != inv_q.
  - at that same edge, all valid bits are cleared (flush); stage data is left unchanged
  - din is not captured into stage 1 at that edge
- Pipeline: on an enabled edge with no change, stage1 <= din ^ {WIDTH{inv_q}} and vld1 <= din_vld. Stage i <= stage i-1 ^ {WIDTH{inv_q}} and vld_i <= vld_{i-1}.
- Output with dly_q = D >= 1: dout = stage D, dout_vld = vld_D. A sample accepted at enabled edge k appears after enabled edge k+D-1, so it is visible D-1 cycles after acceptance when en is held high. Its value is din XOR {WIDTH{inv_q & D[0]}}.
- Output with dly_q = 0: combinational bypass, dout = din, dout_vld = din_vld. No inversion and no flush effect.
- Stall: with en=0, dout and dout_vld are held. Unselected stages also hold.
- FSM (state enum RUN, SETTLE):
  - RUN -> SETTLE on a config change when the new D >= 1; settle counter <= 0.
  - In SETTLE, the counter increments on each enabled edge. SETTLE -> RUN on the enabled edge where counter == D-1.
  - A config change while in SETTLE restarts the count with the new D. A change to D = 0 goes directly to RUN.
  - cfg_busy = (state == SETTLE).
- Simultaneous events:
  - config change and en=1 at the same edge: the flush wins and nothing shifts
  - rst with anything: reset wins
- All stage valid bits shift even when unselected, so a later delay increase does not need special handling; the flush already covers it.

Decomposition:
- Package prog_inv_delay_pkg holds:
  - state_t enum {RUN, SETTLE}
  - function clamp_sel(sel, max) returning SEL_W bits
  - localparam DEFAULT_WIDTH=8 and DEFAULT_MAX_DEPTH=8
- Sub-module inv_reg_stage (WIDTH): one register holding data and valid, with inputs clk, rst, en, flush, inv, d, d_vld and outputs q, q_vld. It is instantiated MAX_DEPTH times in a generate loop. The top level holds the tap mux, the config registers and the FSM.

Test Plan:
1. Reset: drive rst=1 for 2 cycles with din=8'hFF, din_vld=1 -> dout=0, dout_vld=0, cfg_busy=0 throughout.
2. Inverter-chain equivalence: dly_sel=6, inv_mode=1, din=8'hA5 valid for one cycle -> dout=8'hA5 with dout_vld=1 five cycles after acceptance, for one cycle. Repeat with dly_sel=5 -> dout=8'h5A four cycles after acceptance.
3. Stall: dly_sel=3, inv_mode=0, stream 8'h01, 8'h02, 8'h03 with en held low for 2 cycles mid-stream -> output order 01, 02, 03 is preserved and each output is held during the stall.
4. Reconfiguration mid-flight: stream with dly_sel=4, then change to 2 -> dout_vld=0 at the edge of the change. cfg_busy=1 for exactly 2 enabled cycles and then 0. New data appears one cycle after acceptance with no stale samples.
5. Bypass and clamp: dly_sel=0 with din=8'h3C -> dout=8'h3C in the same cycle. dly_sel=15 with MAX_DEPTH=8 -> behaves as delay 8 (output seven cycles after acceptance).
6. Reset mid-operation: assert rst while in SETTLE with data in flight -> next cycle all outputs are 0, state is RUN and the delay reverts to 0 (bypass).
